// File: rtl/fft2d_seq_pkg.sv
// Shared codes for the 2D FFT sequencer: FSM state codes, unit command mode
// codes and run-type codes.
package fft2d_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ROW   = 3'd1;
    localparam logic [2:0] ST_XPOSE = 3'd2;
    localparam logic [2:0] ST_COL   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] CMD_MODE_NONE  = 4'b0000;
    localparam logic [3:0] CMD_MODE_ROW   = 4'b0010;
    localparam logic [3:0] CMD_MODE_COL   = 4'b0011;
    localparam logic [3:0] CMD_MODE_XPOSE = 4'b0100;

    localparam logic [1:0] RUN_ROW_ONLY = 2'b00;
    localparam logic [1:0] RUN_FULL     = 2'b01;
    localparam logic [1:0] RUN_COL_ONLY = 2'b10;
    localparam logic [1:0] RUN_RSVD     = 2'b11;

    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_ROW) || (st == ST_XPOSE) || (st == ST_COL);
    endfunction

endpackage

// File: rtl/fft2d_stage_counter.sv
// Per-stage cycle counter: clear forces zero, otherwise counts up and parks
// at the terminal value so it never wraps.
module fft2d_stage_counter #(
    parameter int CNT_W = 16
) (
    input  logic             extc_base_clock,
    input  logic             extc_asyn_reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc    = (count_q == last);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!tc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge extc_base_clock or posedge extc_asyn_reset) begin
        if (extc_asyn_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fft2d_sequencer.sv
// Sequences the 1D FFT units through row, transpose and column stages and
// broadcasts a unified command plus a latched per-unit enable mask.
module fft2d_sequencer
    import fft2d_seq_pkg::*;
#(
    parameter int SEQ_MODE_W   = 4,
    parameter int N_UNITS      = 32,
    parameter int CNT_W        = 16,
    parameter int ROW_CYCLES   = 646,
    parameter int XPOSE_CYCLES = 1024,
    parameter int COL_CYCLES   = 646
) (
    input  logic                  extc_base_clock,
    input  logic                  extc_asyn_reset,
    input  logic                  extc_start,
    input  logic                  extc_abort,
    input  logic [1:0]            extc_mode,
    input  logic [N_UNITS-1:0]    extc_unit_mask,
    output logic                  exts_busy,
    output logic                  exts_done,
    output logic                  exts_error,
    output logic [2:0]            exts_stage,
    output logic [CNT_W-1:0]      exts_cycle,
    output logic [SEQ_MODE_W+1:0] f_unified_command,
    output logic [N_UNITS-1:0]    f_unit_enable
);

    // Control is level-sampled on the rising edge: extc_start only matters in
    // IDLE, extc_abort wins over extc_start, and there is no back-pressure.
    logic [2:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [N_UNITS-1:0]    mask_q, mask_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [SEQ_MODE_W+1:0] cmd_q, cmd_d;
    logic [N_UNITS-1:0]    enable_q, enable_d;

    logic                  cnt_clear;
    logic [CNT_W-1:0]      cnt_last;
    logic                  cnt_tc;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (extc_start && !extc_abort) begin
                    if (extc_mode == RUN_RSVD) begin
                        error_d = 1'b1;
                    end else begin
                        mode_d  = extc_mode;
                        mask_d  = extc_unit_mask;
                        state_d = (extc_mode == RUN_COL_ONLY) ? ST_COL : ST_ROW;
                    end
                end
            end
            ST_ROW:   if (cnt_tc) state_d = (mode_q == RUN_FULL) ? ST_XPOSE : ST_DONE;
            ST_XPOSE: if (cnt_tc) state_d = ST_COL;
            ST_COL:   if (cnt_tc) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (extc_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Output flops are loaded with the decode of the next state, so each one
    // always matches the decode of the current state register.
    always_comb begin
        busy_d   = state_is_busy(state_d);
        done_d   = (state_d == ST_DONE);
        enable_d = busy_d ? mask_d : '0;
        case (state_d)
            ST_ROW:   cmd_d = {2'b01, SEQ_MODE_W'(CMD_MODE_ROW)};
            ST_XPOSE: cmd_d = {2'b01, SEQ_MODE_W'(CMD_MODE_XPOSE)};
            ST_COL:   cmd_d = {2'b01, SEQ_MODE_W'(CMD_MODE_COL)};
            default:  cmd_d = {2'b10, SEQ_MODE_W'(CMD_MODE_NONE)};
        endcase
    end

    always_comb begin
        case (state_q)
            ST_ROW:   cnt_last = CNT_W'(ROW_CYCLES - 1);
            ST_XPOSE: cnt_last = CNT_W'(XPOSE_CYCLES - 1);
            ST_COL:   cnt_last = CNT_W'(COL_CYCLES - 1);
            default:  cnt_last = '0;
        endcase
        cnt_clear = (state_d != state_q) || !state_is_busy(state_q);
    end

    always_ff @(posedge extc_base_clock or posedge extc_asyn_reset) begin
        if (extc_asyn_reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= RUN_ROW_ONLY;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            cmd_q    <= {2'b10, SEQ_MODE_W'(CMD_MODE_NONE)};
            enable_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            cmd_q    <= cmd_d;
            enable_q <= enable_d;
        end
    end

    fft2d_stage_counter #(
        .CNT_W(CNT_W)
    ) u_stage_counter (
        .extc_base_clock(extc_base_clock),
        .extc_asyn_reset(extc_asyn_reset),
        .clear          (cnt_clear),
        .last           (cnt_last),
        .count          (exts_cycle),
        .tc             (cnt_tc)
    );

    assign exts_busy         = busy_q;
    assign exts_done         = done_q;
    assign exts_error        = error_q;
    assign exts_stage        = state_q;
    assign f_unified_command = cmd_q;
    assign f_unit_enable     = enable_q;

endmodule

// File: tb/tb_fft2d_sequencer.sv
// Directed bench for fft2d_sequencer: the driver pushes the expected output
// vector for every cycle, a monitor pops and compares one per cycle.
module tb_fft2d_sequencer;

  localparam int OBS_W = 60;
  localparam logic [5:0] CMD_I = 6'b100000;
  localparam logic [5:0] CMD_R = 6'b010010;
  localparam logic [5:0] CMD_X = 6'b010100;
  localparam logic [5:0] CMD_C = 6'b010011;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] mask;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  stage;
  logic [15:0] cycle;
  logic [5:0]  cmd;
  logic [31:0] enable;

  logic [OBS_W-1:0] exp_q[$];
  string            lbl_q[$];
  int               n_checks;
  int               n_fail;

  fft2d_sequencer #(
    .SEQ_MODE_W(4), .N_UNITS(32), .CNT_W(16),
    .ROW_CYCLES(4), .XPOSE_CYCLES(3), .COL_CYCLES(5)
  ) dut (
    .extc_base_clock(clk),
    .extc_asyn_reset(rst),
    .extc_start(start),
    .extc_abort(abort),
    .extc_mode(mode),
    .extc_unit_mask(mask),
    .exts_busy(busy),
    .exts_done(done),
    .exts_error(error),
    .exts_stage(stage),
    .exts_cycle(cycle),
    .f_unified_command(cmd),
    .f_unit_enable(enable)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [OBS_W-1:0] obs(input logic b, input logic d, input logic e,
                                           input logic [2:0] s, input logic [15:0] c,
                                           input logic [5:0] cm, input logic [31:0] en);
    return {b, d, e, s, c, cm, en};
  endfunction

  function automatic logic [OBS_W-1:0] got_obs();
    return {busy, done, error, stage, cycle, cmd, enable};
  endfunction

  function automatic void check(input string l, input logic [OBS_W-1:0] g, input logic [OBS_W-1:0] e);
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got busy=%0b done=%0b err=%0b stage=%0d cyc=%0d cmd=%b en=%h, required busy=%0b done=%0b err=%0b stage=%0d cyc=%0d cmd=%b en=%h",
               l, g[59], g[58], g[57], g[56:54], g[53:38], g[37:32], g[31:0],
               e[59], e[58], e[57], e[56:54], e[53:38], e[37:32], e[31:0]);
    end
  endfunction

  // scoreboard monitor
  initial begin
    logic [OBS_W-1:0] e;
    string l;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        check(l, got_obs(), e);
      end
    end
  end

  // driver tasks
  task automatic step(input logic st, input logic ab, input logic [1:0] md,
                      input logic [31:0] mk, input logic [OBS_W-1:0] e, input string l);
    start = st;
    abort = ab;
    mode  = md;
    mask  = mk;
    exp_q.push_back(e);
    lbl_q.push_back(l);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string l);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 2'b00, 32'h0, obs(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, CMD_I, 32'h0), l);
  endtask

  // Expect cycles [from, to] of a busy stage; inputs held at st/md/mk.
  task automatic stage_run(input logic [2:0] s, input int from, input int to,
                           input logic [5:0] cm, input logic [31:0] en,
                           input logic st, input logic [1:0] md, input logic [31:0] mk,
                           input string l);
    for (int i = from; i <= to; i++)
      step(st, 1'b0, md, mk, obs(1'b1, 1'b0, 1'b0, s, 16'(i), cm, en), l);
  endtask

  task automatic done_cyc(input string l);
    step(1'b0, 1'b0, 2'b00, 32'h0, obs(1'b0, 1'b1, 1'b0, 3'd4, 16'd0, CMD_I, 32'h0), l);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;
    mask  = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_state", got_obs(), obs(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, CMD_I, 32'h0));
    rst = 1'b0;
    idle(2, "idle_after_reset");

    // full run, mode 01; inputs changed after start to prove latching
    step(1'b1, 1'b0, 2'b01, 32'hF0F0F0F0,
         obs(1'b1, 1'b0, 1'b0, 3'd1, 16'd0, CMD_R, 32'hF0F0F0F0), "full_row");
    stage_run(3'd1, 1, 3, CMD_R, 32'hF0F0F0F0, 1'b0, 2'b10, 32'h0, "full_row");
    stage_run(3'd2, 0, 2, CMD_X, 32'hF0F0F0F0, 1'b0, 2'b00, 32'h0, "full_xpose");
    stage_run(3'd3, 0, 4, CMD_C, 32'hF0F0F0F0, 1'b0, 2'b00, 32'h0, "full_col");
    done_cyc("full_done");
    idle(2, "full_idle");

    // row only
    step(1'b1, 1'b0, 2'b00, 32'h0000FFFF,
         obs(1'b1, 1'b0, 1'b0, 3'd1, 16'd0, CMD_R, 32'h0000FFFF), "rowonly_row");
    stage_run(3'd1, 1, 3, CMD_R, 32'h0000FFFF, 1'b0, 2'b00, 32'h0, "rowonly_row");
    done_cyc("rowonly_done");
    idle(1, "rowonly_idle");

    // column only
    step(1'b1, 1'b0, 2'b10, 32'h12345678,
         obs(1'b1, 1'b0, 1'b0, 3'd3, 16'd0, CMD_C, 32'h12345678), "colonly_col");
    stage_run(3'd3, 1, 4, CMD_C, 32'h12345678, 1'b0, 2'b00, 32'h0, "colonly_col");
    done_cyc("colonly_done");
    idle(1, "colonly_idle");

    // abort at XPOSE cycle 1
    step(1'b1, 1'b0, 2'b01, 32'hAAAA5555,
         obs(1'b1, 1'b0, 1'b0, 3'd1, 16'd0, CMD_R, 32'hAAAA5555), "abort_row");
    stage_run(3'd1, 1, 3, CMD_R, 32'hAAAA5555, 1'b0, 2'b01, 32'h0, "abort_row");
    stage_run(3'd2, 0, 1, CMD_X, 32'hAAAA5555, 1'b0, 2'b01, 32'h0, "abort_xpose");
    step(1'b0, 1'b1, 2'b01, 32'h0,
         obs(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, CMD_I, 32'h0), "abort_to_idle");
    idle(3, "abort_no_done");

    // reserved mode rejection
    step(1'b1, 1'b0, 2'b11, 32'hFFFFFFFF,
         obs(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, CMD_I, 32'h0), "rsvd_error");
    idle(2, "rsvd_error_clear");

    // abort beats start in IDLE
    step(1'b1, 1'b1, 2'b01, 32'hFFFFFFFF,
         obs(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, CMD_I, 32'h0), "abort_beats_start");
    idle(1, "abort_beats_start_idle");

    // start held through COL and DONE: ignored until the IDLE cycle after DONE
    step(1'b1, 1'b0, 2'b10, 32'h0F0F0F0F,
         obs(1'b1, 1'b0, 1'b0, 3'd3, 16'd0, CMD_C, 32'h0F0F0F0F), "restart_col");
    stage_run(3'd3, 1, 4, CMD_C, 32'h0F0F0F0F, 1'b1, 2'b00, 32'hCAFEF00D, "restart_col_ignore");
    step(1'b1, 1'b0, 2'b00, 32'hCAFEF00D,
         obs(1'b0, 1'b1, 1'b0, 3'd4, 16'd0, CMD_I, 32'h0), "restart_done");
    step(1'b1, 1'b0, 2'b00, 32'hCAFEF00D,
         obs(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, CMD_I, 32'h0), "restart_done_ignore");
    step(1'b1, 1'b0, 2'b00, 32'hCAFEF00D,
         obs(1'b1, 1'b0, 1'b0, 3'd1, 16'd0, CMD_R, 32'hCAFEF00D), "restart_new_run");
    stage_run(3'd1, 1, 3, CMD_R, 32'hCAFEF00D, 1'b0, 2'b00, 32'h0, "restart_row");
    done_cyc("restart_row_done");
    idle(1, "restart_idle");

    // asynchronous reset at ROW cycle 2
    step(1'b1, 1'b0, 2'b01, 32'h87654321,
         obs(1'b1, 1'b0, 1'b0, 3'd1, 16'd0, CMD_R, 32'h87654321), "rst_row");
    stage_run(3'd1, 1, 2, CMD_R, 32'h87654321, 1'b0, 2'b01, 32'h0, "rst_row");
    rst = 1'b1;
    #1;
    check("async_reset_midrun", got_obs(), obs(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, CMD_I, 32'h0));
    idle(1, "reset_held");
    rst = 1'b0;
    idle(6, "after_midrun_reset");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft2d_sequencer.md
FFT2D_SEQUENCER -- requirements
Module: fft2d_sequencer

Interface
REQ-001 SHALL have parameter SEQ_MODE_W, default 4, width of unit mode code (equal to SEQUENCE_MODE_LENGTH).
REQ-002 SHALL have parameter N_UNITS, default 32, number of 1D FFT units driven.
REQ-003 SHALL have parameter CNT_W, default 16, cycle counter width.
REQ-004 SHALL have parameter ROW_CYCLES, default 646, row-FFT stage length in cycles.
REQ-005 SHALL have parameter XPOSE_CYCLES, default 1024, transpose stage length in cycles.
REQ-006 SHALL have parameter COL_CYCLES, default 646, column-FFT stage length in cycles.
REQ-007 SHALL have port extc_base_clock, in, 1, rising-edge clock.
REQ-008 SHALL have port extc_asyn_reset, in, 1, reset; asynchronous, active-high.
REQ-009 SHALL have port extc_start, in, 1, run request.
REQ-010 SHALL have port extc_abort, in, 1, terminate current run.
REQ-011 SHALL have port extc_mode, in, 2, run type: 00 row only, 01 row+transpose+column, 10 column only, 11 reserved.
REQ-012 SHALL have port extc_unit_mask, in, N_UNITS, per-unit enable request.
REQ-013 SHALL have port exts_busy, out, 1, run in progress.
REQ-014 SHALL have port exts_done, out, 1, one-cycle completion pulse.
REQ-015 SHALL have port exts_error, out, 1, one-cycle reserved-mode rejection pulse.
REQ-016 SHALL have port exts_stage, out, 3, current state code.
REQ-017 SHALL have port exts_cycle, out, CNT_W, cycle index within current stage.
REQ-018 SHALL have port f_unified_command, out, SEQ_MODE_W+2, {clear, run, mode code} to all units.
REQ-019 SHALL have port f_unit_enable, out, N_UNITS, latched unit mask, zero outside busy stages.

Function
REQ-020 SHALL implement states IDLE=0, ROW=1, XPOSE=2, COL=3, DONE=4; all outputs registered, decoded from current state.
REQ-021 SHALL, in IDLE, accept extc_start=1 with mode 00/01 into ROW, mode 10 into COL, latching extc_mode and extc_unit_mask on that edge.
REQ-022 SHALL, in IDLE, on extc_start=1 with mode 11, stay IDLE and assert exts_error for exactly one cycle.
REQ-023 SHALL ignore extc_start in every non-IDLE state.
REQ-024 SHALL hold each stage for exactly its *_CYCLES cycles, exts_cycle counting 0..N-1 and resetting to 0 on each stage entry.
REQ-025 SHALL transition at exts_cycle==N-1: ROW to DONE (mode 00) or XPOSE (mode 01); XPOSE to COL; COL to DONE.
REQ-026 SHALL spend exactly one cycle in DONE with exts_done=1, exts_busy=0, then return to IDLE.
REQ-027 SHALL assert exts_busy=1 in ROW, XPOSE and COL only.
REQ-028 SHALL drive f_unified_command: IDLE/DONE {1,0,0000}; ROW {0,1,0010}; XPOSE {0,1,0100}; COL {0,1,0011}.
REQ-029 SHALL, on extc_abort=1 in ROW/XPOSE/COL/DONE, enter IDLE next cycle with no exts_done pulse; abort beats start when both are high in IDLE.
REQ-030 SHALL require 1 <= each *_CYCLES <= 2^CNT_W; the counter never wraps past N-1.

Reset
REQ-031 SHALL, on reset, force IDLE, exts_busy=0, exts_done=0, exts_error=0, exts_stage=0, exts_cycle=0, f_unit_enable=0, f_unified_command={1,0,0000}, latched mode 00.
REQ-032 SHALL, on reset asserted mid-run, abandon the run immediately with no exts_done pulse.

Structure
REQ-033 SHALL place state codes, command mode codes (0000/0010/0011/0100) and run-mode codes in shared package fft2d_seq_pkg.
REQ-034 SHALL instantiate one sub-module fft2d_stage_counter (load/clear, terminal-count flag, parameter CNT_W).

Verification (ROW=4, XPOSE=3, COL=5)
REQ-035 SHALL test mode 01 start, mask 0xF0F0F0F0: busy for 12 cycles, stage sequence 1x4, 2x3, 3x5, done pulse on cycle 13, f_unit_enable=0xF0F0F0F0 while busy.
REQ-036 SHALL test mode 00: 4 ROW cycles, then DONE; mode 10: 5 COL cycles, then DONE; no XPOSE in either.
REQ-037 SHALL test extc_abort at XPOSE cycle 1: IDLE next cycle, command {1,0,0000}, no done pulse.
REQ-038 SHALL test mode 11 start: one-cycle exts_error, state stays IDLE, busy stays 0.
REQ-039 SHALL test start re-asserted during COL and during DONE: ignored; start in the IDLE cycle after DONE begins a new run.
REQ-040 SHALL test reset at ROW cycle 2: all outputs at reset values before the next clock edge.
